// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcode encodings, flag bit positions, flag-class decode.
// Also used by the branch/PC logic.
package cpu_pkg;

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_ADD    = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB    = 4'b0001;
  localparam logic [OPW-1:0] OP_XOR    = 4'b0010;
  localparam logic [OPW-1:0] OP_RED    = 4'b0011;
  localparam logic [OPW-1:0] OP_SLL    = 4'b0100;
  localparam logic [OPW-1:0] OP_SRA    = 4'b0101;
  localparam logic [OPW-1:0] OP_ROR    = 4'b0110;
  localparam logic [OPW-1:0] OP_PADDSB = 4'b0111;
  localparam logic [OPW-1:0] OP_LW     = 4'b1000;
  localparam logic [OPW-1:0] OP_SW     = 4'b1001;
  localparam logic [OPW-1:0] OP_LLB    = 4'b1010;
  localparam logic [OPW-1:0] OP_LHB    = 4'b1011;
  localparam logic [OPW-1:0] OP_B      = 4'b1100;
  localparam logic [OPW-1:0] OP_BR     = 4'b1101;
  localparam logic [OPW-1:0] OP_PCS    = 4'b1110;
  localparam logic [OPW-1:0] OP_HLT    = 4'b1111;

  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 2;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } flag_state_t;

  function automatic logic writes_nzv(input logic [OPW-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic writes_z_only(input logic [OPW-1:0] op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  function automatic logic is_hlt(input logic [OPW-1:0] op);
    return op == OP_HLT;
  endfunction

endpackage

// File: rtl/flag_reg_if.sv
// Execute-stage to flag-register bundle. master = execute/ALU side, slave = flag_reg.
// FLAG_BYPASS_EN adds the combinational flag_next signal.
interface flag_reg_if #(
  parameter int unsigned DW  = 16,
  parameter int unsigned OPW = 4
) ();
  logic [OPW-1:0] opcode;
  logic [DW-1:0]  alu_result;
  logic           alu_ovfl;
  logic           stall;
  logic [2:0]     flag;
  logic [2:0]     flag_valid;
  logic           halted;
`ifdef FLAG_BYPASS_EN
  logic [2:0]     flag_next;

  modport master (
    output opcode, alu_result, alu_ovfl, stall,
    input  flag, flag_valid, halted, flag_next
  );
  modport slave (
    input  opcode, alu_result, alu_ovfl, stall,
    output flag, flag_valid, halted, flag_next
  );
`else
  modport master (
    output opcode, alu_result, alu_ovfl, stall,
    input  flag, flag_valid, halted
  );
  modport slave (
    input  opcode, alu_result, alu_ovfl, stall,
    output flag, flag_valid, halted
  );
`endif
endinterface

// File: rtl/flag_reg_next.sv
// Combinational next-flag / next-valid computation for a retiring instruction.
module flag_next_logic
  import cpu_pkg::*;
#(
  parameter int unsigned DW  = 16,
  parameter int unsigned OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic [DW-1:0]  alu_result,
  input  logic           alu_ovfl,
  input  logic           ret,
  input  logic [2:0]     flag_q,
  input  logic [2:0]     valid_q,
  output logic [2:0]     flag_d,
  output logic [2:0]     valid_d
);

  always_comb begin
    flag_d  = flag_q;
    valid_d = valid_q;
    if (ret) begin
      if (writes_nzv(opcode)) begin
        flag_d[FLAG_N] = alu_result[DW-1];
        flag_d[FLAG_Z] = (alu_result == '0);
        flag_d[FLAG_V] = alu_ovfl;
        valid_d        = '1;
      end else if (writes_z_only(opcode)) begin
        flag_d[FLAG_Z]  = (alu_result == '0);
        valid_d[FLAG_Z] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flag_reg.sv
// Architectural N/Z/V flag register with RUN/HALTED control.
// Optional macro FLAG_BYPASS_EN exposes the combinational flag_next output.
module flag_reg
  import cpu_pkg::*;
#(
  parameter int unsigned DW  = 16,
  parameter int unsigned OPW = 4
) (
  input  logic       clk,
  input  logic       rst,
  flag_reg_if.slave  bus
);

  flag_state_t state;
  logic [2:0]  flag_q, valid_q;
  logic [2:0]  flag_d, valid_d;
  logic        ret;

  assign ret = (state == ST_RUN) && !bus.stall;

  flag_next_logic #(
    .DW  (DW),
    .OPW (OPW)
  ) u_next (
    .opcode     (bus.opcode),
    .alu_result (bus.alu_result),
    .alu_ovfl   (bus.alu_ovfl),
    .ret        (ret),
    .flag_q     (flag_q),
    .valid_q    (valid_q),
    .flag_d     (flag_d),
    .valid_d    (valid_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      flag_q  <= '0;
      valid_q <= '0;
    end else begin
      flag_q  <= flag_d;
      valid_q <= valid_d;
      case (state)
        ST_RUN:    if (ret && is_hlt(bus.opcode)) state <= ST_HALTED;
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

  assign bus.flag       = flag_q;
  assign bus.flag_valid = valid_q;
  assign bus.halted     = (state == ST_HALTED);

`ifdef FLAG_BYPASS_EN
  // Not gated by rst: shows the value a retiring writer would produce.
  assign bus.flag_next = flag_d;
`endif

endmodule

// File: tb/tb_flag_reg.sv
// Self-checking bench for flag_reg: directed scenarios plus randomized traffic
// compared against a behavioural flag model.
module tb_flag_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model state
  bit m_n, m_z, m_v;
  bit m_vn, m_vz, m_vv;
  bit m_halted;

  flag_reg_if #(.DW(16), .OPW(4)) bus ();

  flag_reg #(.DW(16), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one instruction for one clock, advance the model, check registered outputs.
  task automatic step(input string tag, input logic [3:0] op, input logic [15:0] res,
                      input logic ov, input logic st, input logic r);
    bit n, z, v, vn, vz, vv, h;
    bit retire;
    bus.opcode     = op;
    bus.alu_result = res;
    bus.alu_ovfl   = ov;
    bus.stall      = st;
    rst            = r;
    n = m_n; z = m_z; v = m_v; vn = m_vn; vz = m_vz; vv = m_vv; h = m_halted;
    retire = !m_halted && !st;
    if (retire) begin
      if (op == 4'd0 || op == 4'd1) begin
        n = res[15]; z = (res == 16'd0); v = ov;
        vn = 1; vz = 1; vv = 1;
      end else if (op inside {4'd2, 4'd4, 4'd5, 4'd6}) begin
        z = (res == 16'd0); vz = 1;
      end else if (op == 4'd15) begin
        h = 1;
      end
    end
`ifdef FLAG_BYPASS_EN
    #1;
    chk({tag, ".flag_next"}, bus.flag_next, {v, z, n});
`endif
    if (r) begin
      n = 0; z = 0; v = 0; vn = 0; vz = 0; vv = 0; h = 0;
    end
    m_n = n; m_z = z; m_v = v; m_vn = vn; m_vz = vz; m_vv = vv; m_halted = h;
    @(posedge clk);
    #1;
    chk({tag, ".flag"},       bus.flag,       {m_v, m_z, m_n});
    chk({tag, ".flag_valid"}, bus.flag_valid, {m_vv, m_vz, m_vn});
    chk({tag, ".halted"},     {2'b00, bus.halted}, {2'b00, m_halted});
  endtask

  initial begin
    bus.opcode = 4'd0; bus.alu_result = '0; bus.alu_ovfl = 1'b0; bus.stall = 1'b0;
    m_n = 1; m_z = 1; m_v = 1; m_vn = 1; m_vz = 1; m_vv = 1; m_halted = 1;

    step("reset",       4'd0,  16'h1234, 1'b1, 1'b0, 1'b1);
    chk("reset_const", bus.flag, 3'b000);
    step("add_zero",    4'd0,  16'h0000, 1'b0, 1'b0, 1'b0);
    chk("add_zero_const", bus.flag, 3'b010);
    step("sub_neg_ov",  4'd1,  16'h8000, 1'b1, 1'b0, 1'b0);
    chk("sub_const", bus.flag, 3'b101);
    step("xor_one",     4'd2,  16'h0001, 1'b0, 1'b0, 1'b0);
    chk("xor_const", bus.flag, 3'b101);
    step("lw_hold",     4'd8,  16'h0000, 1'b1, 1'b0, 1'b0);
    step("add_stalled", 4'd0,  16'h0000, 1'b0, 1'b1, 1'b0);
    chk("stall_const", bus.flag, 3'b101);
    step("add_unstall", 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0);
    chk("unstall_const", bus.flag, 3'b010);
    step("hlt_stalled", 4'd15, 16'h0000, 1'b0, 1'b1, 1'b0);
    step("sub_ffff",    4'd1,  16'hFFFF, 1'b0, 1'b0, 1'b0);
    chk("sub_ffff_const", bus.flag, 3'b001);
    step("add_rst",     4'd0,  16'h0000, 1'b1, 1'b0, 1'b1);
    step("ror_zero",    4'd6,  16'h0000, 1'b1, 1'b0, 1'b0);
    chk("ror_valid_const", bus.flag_valid, 3'b010);
    step("hlt",         4'd15, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("hlt_const", {2'b00, bus.halted}, 3'b001);
    step("add_halted",  4'd0,  16'h0000, 1'b1, 1'b0, 1'b0);
    step("hlt_rst",     4'd15, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("hlt_rst_const", bus.flag_valid, 3'b000);

    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [15:0] res;
      op  = 4'($urandom_range(0, 15));
      res = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      step("rand", op, res, 1'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 24) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
